// File: rtl/sa4_refill_ctrl_pkg.sv
// Shared definitions for the SA4 cache refill path: default widths, the
// beats-per-line derivation and the refill controller state encoding.
package sa4_cache_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned CNT_W    = 16;

    // A word is 4 bytes, so a line of 2**off_w bytes holds 2**(off_w-2) words.
    function automatic int unsigned beats_of(input int unsigned off_w);
        return 32'(1) << (off_w - 2);
    endfunction

    localparam int unsigned BEATS  = beats_of(OFFSET_W);
    localparam int unsigned BEAT_W = OFFSET_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sa4_refill_ctrl_if.sv
// Refill bus bundle: cache miss handshake, memory burst request/response and
// fill beats back to the cache.
//   master : refill controller view (drives miss_ready, mem_req_*, fill_*)
//   slave  : cache/memory view (drives miss_*, mem_req_ready, mem_rsp_*)
interface sa4_refill_ctrl_if
    import sa4_cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = sa4_cache_pkg::ADDR_W,
    parameter int unsigned DATA_W   = sa4_cache_pkg::DATA_W,
    parameter int unsigned OFFSET_W = sa4_cache_pkg::OFFSET_W
) ();

    logic                  miss_valid;
    logic [ADDR_W-1:0]     miss_addr;
    logic                  miss_ready;

    logic                  mem_req_valid;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_ready;

    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_data;

    logic                  fill_valid;
    logic [OFFSET_W-3:0]   fill_idx;
    logic [DATA_W-1:0]     fill_data;
    logic [ADDR_W-1:0]     fill_addr;
    logic                  fill_done;

    modport master (
        input  miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output miss_ready, mem_req_valid, mem_req_addr,
               fill_valid, fill_idx, fill_data, fill_addr, fill_done
    );

    modport slave (
        output miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  miss_ready, mem_req_valid, mem_req_addr,
               fill_valid, fill_idx, fill_data, fill_addr, fill_done
    );

endinterface

// File: rtl/sa4_refill_ctrl.sv
// Miss-refill controller behind SA4_CACHE. Accepts one miss at a time, issues
// one line-aligned burst read, streams the returned words back as registered
// fill beats and pulses fill_done with the last beat. Also keeps a saturating
// count of accepted misses and a sticky flag for responses outside RECV.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        refill bundle (master view)
//   miss_count accepted misses, saturating at all-ones
//   err_stray  sticky: mem_rsp_valid seen outside RECV
module sa4_refill_ctrl
    import sa4_cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = sa4_cache_pkg::ADDR_W,
    parameter int unsigned DATA_W   = sa4_cache_pkg::DATA_W,
    parameter int unsigned OFFSET_W = sa4_cache_pkg::OFFSET_W,
    parameter int unsigned CNT_W    = sa4_cache_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    sa4_refill_ctrl_if.master  bus,
    output logic [CNT_W-1:0]   miss_count,
    output logic               err_stray
);

    localparam int unsigned BW     = OFFSET_W - 2;
    localparam int unsigned NBEATS = beats_of(OFFSET_W);

    state_e              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic                miss_ready_q, miss_ready_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                fill_valid_q, fill_valid_d;
    logic [BW-1:0]       fill_idx_q, fill_idx_d;
    logic [DATA_W-1:0]   fill_data_q, fill_data_d;
    logic                fill_done_q, fill_done_d;
    logic [CNT_W-1:0]    miss_count_q, miss_count_d;
    logic                err_stray_q, err_stray_d;

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            line_addr_q     <= '0;
            miss_ready_q    <= 1'b1;
            mem_req_valid_q <= 1'b0;
            fill_valid_q    <= 1'b0;
            fill_idx_q      <= '0;
            fill_data_q     <= '0;
            fill_done_q     <= 1'b0;
            miss_count_q    <= '0;
            err_stray_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            line_addr_q     <= line_addr_d;
            miss_ready_q    <= miss_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            fill_valid_q    <= fill_valid_d;
            fill_idx_q      <= fill_idx_d;
            fill_data_q     <= fill_data_d;
            fill_done_q     <= fill_done_d;
            miss_count_q    <= miss_count_d;
            err_stray_q     <= err_stray_d;
        end
    end

    // Next state and next outputs.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        line_addr_d  = line_addr_q;
        fill_valid_d = 1'b0;
        fill_idx_d   = fill_idx_q;
        fill_data_d  = fill_data_q;
        miss_count_d = miss_count_q;
        err_stray_d  = err_stray_q | (bus.mem_rsp_valid && (state_q != RECV));

        case (state_q)
            IDLE: begin
                if (bus.miss_valid) begin
                    line_addr_d = {bus.miss_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
                    state_d     = REQ;
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + CNT_W'(1);
                    end
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = RECV;
                    beat_d  = '0;
                end
            end
            RECV: begin
                // Only valid responses advance the beat; idle gaps are legal.
                if (bus.mem_rsp_valid) begin
                    fill_valid_d = 1'b1;
                    fill_data_d  = bus.mem_rsp_data;
                    fill_idx_d   = beat_q;
                    beat_d       = beat_q + BW'(1);
                    if (beat_q == BW'(NBEATS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered versions of the state decodes line up with state_q.
        miss_ready_d    = (state_d == IDLE);
        mem_req_valid_d = (state_d == REQ);
        fill_done_d     = (state_d == DONE);
    end

    assign bus.miss_ready    = miss_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = line_addr_q;
    assign bus.fill_valid    = fill_valid_q;
    assign bus.fill_idx      = fill_idx_q;
    assign bus.fill_data     = fill_data_q;
    assign bus.fill_addr     = line_addr_q;
    assign bus.fill_done     = fill_done_q;
    assign miss_count        = miss_count_q;
    assign err_stray         = err_stray_q;

endmodule

// File: tb/tb_sa4_refill_ctrl.sv
// Self-checking bench for sa4_refill_ctrl: directed and random miss
// transactions checked against a transaction-level scoreboard. A second
// instance with a 2-bit counter sees the same stimulus for saturation.
module tb_sa4_refill_ctrl;
    import sa4_cache_pkg::*;

    logic clk;
    logic rst;
    logic [15:0] mc;
    logic [1:0]  mc_s;
    logic        es, es_s;

    sa4_refill_ctrl_if bus ();
    sa4_refill_ctrl_if bus_s ();

    sa4_refill_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .miss_count(mc), .err_stray(es)
    );

    sa4_refill_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s), .miss_count(mc_s), .err_stray(es_s)
    );

    assign bus_s.miss_valid    = bus.miss_valid;
    assign bus_s.miss_addr     = bus.miss_addr;
    assign bus_s.mem_req_ready = bus.mem_req_ready;
    assign bus_s.mem_rsp_valid = bus.mem_rsp_valid;
    assign bus_s.mem_rsp_data  = bus.mem_rsp_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  idx;
    } ev_t;

    ev_t fill_q[$];
    ev_t req_q[$];
    int  done_q[$];

    // Record every observable DUT event away from the active edge.
    always @(negedge clk) begin
        if (bus.fill_valid === 1'b1)
            fill_q.push_back('{cyc, bus.fill_addr, bus.fill_data, bus.fill_idx});
        if (bus.mem_req_valid === 1'b1)
            req_q.push_back('{cyc, bus.mem_req_addr, 32'h0, 2'd0});
        if (bus.fill_done === 1'b1)
            done_q.push_back(cyc);
    end

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    bit err_model = 1'b0;
    int last_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic clear_q();
        fill_q.delete();
        req_q.delete();
        done_q.delete();
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a miss and wait for it to be taken; returns the accept cycle.
    task automatic accept_miss(input logic [31:0] addr, input bit hold,
                               input logic [31:0] next_addr, output int acc);
        bit ok = 1'b0;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = addr;
        acc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.miss_ready === 1'b1) begin
                ok = 1'b1;
                acc = cyc;
                break;
            end
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        next_cyc();
        n_acc++;
        if (hold) bus.miss_addr = next_addr;
        else      bus.miss_valid = 1'b0;
    endtask

    task automatic do_req(input int wait_cyc);
        repeat (wait_cyc) next_cyc();
        bus.mem_req_ready = 1'b1;
        next_cyc();
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic send_rsp(input int gap, input logic [31:0] data, output int rc);
        repeat (gap) next_cyc();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = data;
        rc = cyc;
        next_cyc();
        bus.mem_rsp_valid = 1'b0;
    endtask

    // One complete refill, checked against the expected transaction shape.
    task automatic do_miss(input logic [31:0] addr, input int wait_cyc,
                           input int g0, input int g1, input int g2, input int g3,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input bit hold, input logic [31:0] next_addr,
                           input bit b2b);
        logic [31:0] line;
        logic [31:0] dat[4];
        int gap[4];
        int rc[4];
        int acc;
        int dcyc;
        bit ok;
        line = {addr[31:4], 4'h0};
        dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3;
        gap[0] = g0; gap[1] = g1; gap[2] = g2; gap[3] = g3;
        clear_q();

        accept_miss(addr, hold, next_addr, acc);
        if (b2b) chk("b2b_accept_cycle", 64'(acc), 64'(last_done + 1));
        do_req(wait_cyc);
        for (int b = 0; b < 4; b++) send_rsp(gap[b], dat[b], rc[b]);

        ok = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.fill_done === 1'b1) begin
                ok = 1'b1;
                dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("done_timeout", 64'(ok), 64'd1);
        next_cyc();
        last_done = dcyc;

        chk("req_cycles", 64'(req_q.size()), 64'(wait_cyc + 1));
        if (req_q.size() > 0) chk("req_start", 64'(req_q[0].c), 64'(acc + 1));
        foreach (req_q[i]) chk("req_addr", 64'(req_q[i].a), 64'(line));
        chk("fill_beats", 64'(fill_q.size()), 64'd4);
        for (int b = 0; b < 4 && b < fill_q.size(); b++) begin
            chk("fill_idx",  64'(fill_q[b].idx), 64'(b));
            chk("fill_data", 64'(fill_q[b].d),   64'(dat[b]));
            chk("fill_addr", 64'(fill_q[b].a),   64'(line));
            chk("fill_lat",  64'(fill_q[b].c),   64'(rc[b] + 1));
        end
        chk("done_count", 64'(done_q.size()), 64'd1);
        chk("done_cycle", 64'(dcyc), 64'(rc[3] + 1));
        chk("miss_count", 64'(mc), 64'(sat(n_acc, 65535)));
        chk("miss_count_sat", 64'(mc_s), 64'(sat(n_acc, 3)));
        chk("err_stray", 64'(es), 64'(err_model));
    endtask

    initial begin
        int r0, r1;
        logic [31:0] ra;
        rst = 1'b1;
        bus.miss_valid    = 1'b0;
        bus.miss_addr     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;

        // Reset values
        #5 rst = 1'b0;
        #1;
        chk("rst_miss_ready", 64'(bus.miss_ready), 64'd1);
        chk("rst_req_valid",  64'(bus.mem_req_valid), 64'd0);
        chk("rst_req_addr",   64'(bus.mem_req_addr), 64'd0);
        chk("rst_fill_valid", 64'(bus.fill_valid), 64'd0);
        chk("rst_fill_idx",   64'(bus.fill_idx), 64'd0);
        chk("rst_fill_data",  64'(bus.fill_data), 64'd0);
        chk("rst_fill_addr",  64'(bus.fill_addr), 64'd0);
        chk("rst_fill_done",  64'(bus.fill_done), 64'd0);
        chk("rst_miss_count", 64'(mc), 64'd0);
        chk("rst_err_stray",  64'(es), 64'd0);
        #11 rst = 1'b1;
        next_cyc();

        // Single miss, ready on the second REQ cycle
        do_miss(32'h1fffff58, 1, 0, 0, 0, 0,
                32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0, 32'h0, 1'b0);

        // Gapped responses on RECV cycles 1, 4, 5, 9
        do_miss(32'h20000000, 0, 1, 2, 0, 3,
                32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 32'h0, 1'b0);

        // Back-to-back misses with miss_valid held high
        do_miss(32'h3004d960, 0, 0, 0, 0, 0,
                32'h5, 32'h6, 32'h7, 32'h8, 1'b1, 32'h3004caa0, 1'b0);
        do_miss(32'h3004caa0, 2, 0, 1, 0, 0,
                32'h9, 32'hA, 32'hB, 32'hC, 1'b0, 32'h0, 1'b1);

        // Stray response in IDLE sets the sticky flag
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hdeadbeef;
        next_cyc();
        bus.mem_rsp_valid = 1'b0;
        err_model = 1'b1;
        chk("stray_set", 64'(es), 64'd1);
        do_miss(32'h00001234, 0, 0, 0, 0, 0,
                32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 32'h0, 1'b0);

        // Abort with reset after two beats
        accept_miss(32'h40000010, 1'b0, 32'h0, r0);
        do_req(0);
        send_rsp(0, 32'h77, r1);
        send_rsp(0, 32'h78, r1);
        clear_q();
        rst = 1'b0;
        #1;
        chk("abort_miss_ready", 64'(bus.miss_ready), 64'd1);
        chk("abort_fill_valid", 64'(bus.fill_valid), 64'd0);
        chk("abort_req_valid",  64'(bus.mem_req_valid), 64'd0);
        chk("abort_err_stray",  64'(es), 64'd0);
        chk("abort_miss_count", 64'(mc), 64'd0);
        #3 rst = 1'b1;
        n_acc = 0;
        err_model = 1'b0;
        repeat (6) next_cyc();
        chk("abort_no_done", 64'(done_q.size()), 64'd0);
        chk("abort_no_fill", 64'(fill_q.size()), 64'd0);
        chk("abort_no_req",  64'(req_q.size()), 64'd0);

        // Random refills; the 2-bit instance saturates at 3 from the third on
        for (int t = 0; t < 16; t++) begin
            ra = $urandom;
            do_miss(ra, $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom, $urandom, $urandom, $urandom,
                    1'b0, 32'h0, 1'b0);
            repeat ($urandom_range(0, 2)) next_cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
